// File: rtl/can_crc_seq.sv
// CAN CRC-15 transmit sequencer: streams SOF..last data bit into the external CRC unit, then appends its snapshot MSB first.
// Define CAN_CRC_SEQ_EXT_EN to add the ide/id_ext ports and the 39-bit extended header.
module can_crc_seq #(
    parameter int MAX_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [10:0] id,
    input  logic        rtr,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
`ifdef CAN_CRC_SEQ_EXT_EN
    input  logic        ide,
    input  logic [17:0] id_ext,
`endif
    input  logic        bit_tick,
    input  logic [14:0] crc_in,
    output logic        crc_clr,
    output logic        crc_en,
    output logic        crc_bit,
    output logic        bit_out,
    output logic        bit_strobe,
    output logic        crc_phase,
    output logic        busy,
    output logic        done,
    output logic [14:0] crc_value
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HDR, S_DATA, S_SNAP, S_CRC, S_DONE
    } state_t;

    localparam logic [3:0] LP_MAX_LEN  = 4'(MAX_BYTES);
    localparam logic [6:0] LP_CRC_LAST = 7'd14;

    state_t      r_state;
    state_t      w_next;
    logic [38:0] r_hdr;
    logic [63:0] r_data;
    logic [14:0] r_crc_sh;
    logic [14:0] r_crc_value;
    logic [6:0]  r_cnt;
    logic [6:0]  r_hdr_last;
    logic [3:0]  r_len;
    logic        r_snap_wait;
    logic        r_bit_out;
    logic        r_bit_strobe;
    logic        r_crc_en;
    logic        r_crc_clr;
    logic        r_done;
    logic        r_crc_phase;

    logic        w_emit;
    logic        w_emit_bit;
    logic        w_crc_en_nxt;
    logic        w_clr_nxt;
    logic        w_done_nxt;
    logic        w_phase_nxt;
    logic [6:0]  w_data_last;
    logic [38:0] w_hdr_load;
    logic [6:0]  w_hdr_last_load;
    logic [3:0]  w_len_load;

    assign w_data_last = {r_len, 3'b000} - 7'd1;
    assign w_len_load  = rtr ? 4'd0 : ((dlc > LP_MAX_LEN) ? LP_MAX_LEN : dlc);

    // Header is left-aligned in a 39-bit shifter so both formats shift out of bit 38.
    always_comb begin
        w_hdr_load      = {1'b0, id, rtr, 1'b0, 1'b0, dlc, 20'd0};
        w_hdr_last_load = 7'd18;
`ifdef CAN_CRC_SEQ_EXT_EN
        if (ide) begin
            w_hdr_load      = {1'b0, id, 1'b1, 1'b1, id_ext, rtr, 1'b0, 1'b0, dlc};
            w_hdr_last_load = 7'd38;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_CLEAR;
                S_CLEAR: w_next = S_HDR;
                S_HDR:   if (bit_tick && r_cnt == r_hdr_last)
                             w_next = (r_len == 4'd0) ? S_SNAP : S_DATA;
                S_DATA:  if (bit_tick && r_cnt == w_data_last) w_next = S_SNAP;
                S_SNAP:  if (r_snap_wait) w_next = S_CRC;
                S_CRC:   if (bit_tick && r_cnt == LP_CRC_LAST) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_emit     = bit_tick && !abort &&
                     (r_state == S_HDR || r_state == S_DATA || r_state == S_CRC);
        w_emit_bit = 1'b1;
        case (r_state)
            S_HDR:   w_emit_bit = r_hdr[38];
            S_DATA:  w_emit_bit = r_data[63];
            S_CRC:   w_emit_bit = r_crc_sh[14];
            default: w_emit_bit = 1'b1;
        endcase
        w_crc_en_nxt = w_emit && (r_state != S_CRC);
        w_clr_nxt    = abort ? (r_state != S_IDLE) : (r_state == S_IDLE && start);
        w_done_nxt   = !abort && (r_state == S_DONE);
        w_phase_nxt  = r_crc_phase;
        if (abort || w_next == S_IDLE)      w_phase_nxt = 1'b0;
        else if (w_emit && r_state == S_CRC) w_phase_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr        <= '0;
            r_data       <= '0;
            r_crc_sh     <= '0;
            r_crc_value  <= '0;
            r_cnt        <= '0;
            r_hdr_last   <= '0;
            r_len        <= '0;
            r_snap_wait  <= 1'b0;
            r_bit_out    <= 1'b1;
            r_bit_strobe <= 1'b0;
            r_crc_en     <= 1'b0;
            r_crc_clr    <= 1'b0;
            r_done       <= 1'b0;
            r_crc_phase  <= 1'b0;
        end else begin
            r_bit_strobe <= w_emit;
            r_crc_en     <= w_crc_en_nxt;
            r_crc_clr    <= w_clr_nxt;
            r_done       <= w_done_nxt;
            r_crc_phase  <= w_phase_nxt;
            if (w_emit)
                r_bit_out <= w_emit_bit;
            else if (r_state != S_IDLE && w_next == S_IDLE)
                r_bit_out <= 1'b1;

            if (abort) begin
                r_snap_wait <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_hdr      <= w_hdr_load;
                        r_hdr_last <= w_hdr_last_load;
                        r_len      <= w_len_load;
                        r_data     <= data;
                        r_cnt      <= '0;
                    end
                    S_HDR: if (w_emit) begin
                        r_hdr <= {r_hdr[37:0], 1'b0};
                        r_cnt <= (r_cnt == r_hdr_last) ? 7'd0 : r_cnt + 7'd1;
                    end
                    S_DATA: if (w_emit) begin
                        r_data <= {r_data[62:0], 1'b0};
                        r_cnt  <= (r_cnt == w_data_last) ? 7'd0 : r_cnt + 7'd1;
                    end
                    // One idle cycle lets the CRC unit absorb the last covered bit before sampling.
                    S_SNAP: begin
                        if (r_snap_wait) begin
                            r_crc_value <= crc_in;
                            r_crc_sh    <= crc_in;
                            r_cnt       <= '0;
                        end
                        r_snap_wait <= !r_snap_wait;
                    end
                    S_CRC: if (w_emit) begin
                        r_crc_sh <= {r_crc_sh[13:0], 1'b0};
                        r_cnt    <= r_cnt + 7'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign crc_clr    = r_crc_clr;
    assign crc_en     = r_crc_en;
    assign crc_bit    = r_bit_out;
    assign bit_out    = r_bit_out;
    assign bit_strobe = r_bit_strobe;
    assign crc_phase  = r_crc_phase;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign crc_value  = r_crc_value;

endmodule

// File: tb/tb_can_crc_seq.sv
// Bench for can_crc_seq: scoreboard of expected strobed bits plus a behavioural CRC-15 unit on crc_clr/crc_en.
// Exercises the extended header too when CAN_CRC_SEQ_EXT_EN is defined.
module tb_can_crc_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] id = '0;
    logic        rtr = 1'b0;
    logic [3:0]  dlc = '0;
    logic [63:0] data = '0;
`ifdef CAN_CRC_SEQ_EXT_EN
    logic        ide = 1'b0;
    logic [17:0] id_ext = '0;
`endif
    logic        bit_tick = 1'b0;
    logic [14:0] crc_in;
    logic        crc_clr, crc_en, crc_bit, bit_out, bit_strobe, crc_phase, busy, done;
    logic [14:0] crc_value;

    typedef struct packed {
        logic b;
        logic en;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         e;
    int          checks = 0;
    int          errors = 0;
    int          strobe_total = 0;
    int          done_total = 0;
    int          strobe_base, done_base;
    int          exp_strobes;
    logic [14:0] exp_crc, s1_crc, s4_crc;
    logic [14:0] crc_reg;

    can_crc_seq #(.MAX_BYTES(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .id(id), .rtr(rtr), .dlc(dlc), .data(data),
`ifdef CAN_CRC_SEQ_EXT_EN
        .ide(ide), .id_ext(id_ext),
`endif
        .bit_tick(bit_tick), .crc_in(crc_in),
        .crc_clr(crc_clr), .crc_en(crc_en), .crc_bit(crc_bit), .bit_out(bit_out),
        .bit_strobe(bit_strobe), .crc_phase(crc_phase), .busy(busy), .done(done),
        .crc_value(crc_value)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] n;
        n = {c[13:0], 1'b0};
        if (b ^ c[14]) n = n ^ 15'h4599;
        return n;
    endfunction

    // External CRC unit as the sequencer sees it.
    assign crc_in = crc_reg;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)    crc_reg <= '0;
        else if (crc_clr) crc_reg <= '0;
        else if (crc_en)  crc_reg <= crc_step(crc_reg, crc_bit);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bit_strobe) begin
            strobe_total++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: unexpected strobe, bit_out %0b", bit_out);
            end else begin
                e = sb_q.pop_front();
                check("bit_out", 32'(bit_out), 32'(e.b));
                check("crc_bit", 32'(crc_bit), 32'(e.b));
                check("crc_en", 32'(crc_en), 32'(e.en));
                check("crc_phase", 32'(crc_phase), 32'(!e.en));
            end
        end
        if (reset_n && done) done_total++;
    end

    task automatic expect_frame(input logic [10:0] f_id, input logic f_rtr, input logic [3:0] f_dlc,
                                input logic [63:0] f_data, input logic f_ide, input logic [17:0] f_ext);
        logic [14:0] c;
        logic [38:0] hdr;
        int          hlen, len;
        c = '0;
        sb_q.delete();
        if (f_ide) begin
            hdr  = {1'b0, f_id, 1'b1, 1'b1, f_ext, f_rtr, 1'b0, 1'b0, f_dlc};
            hlen = 39;
        end else begin
            hdr  = {20'd0, 1'b0, f_id, f_rtr, 1'b0, 1'b0, f_dlc};
            hlen = 19;
        end
        for (int i = hlen - 1; i >= 0; i--) begin
            sb_q.push_back('{b: hdr[i], en: 1'b1});
            c = crc_step(c, hdr[i]);
        end
        len = f_rtr ? 0 : ((f_dlc > 4'd8) ? 8 : int'(f_dlc));
        for (int i = 0; i < 8 * len; i++) begin
            sb_q.push_back('{b: f_data[63 - i], en: 1'b1});
            c = crc_step(c, f_data[63 - i]);
        end
        for (int i = 14; i >= 0; i--) sb_q.push_back('{b: c[i], en: 1'b0});
        exp_crc     = c;
        exp_strobes = hlen + 8 * len + 15;
    endtask

    task automatic launch(input logic [10:0] f_id, input logic f_rtr, input logic [3:0] f_dlc,
                          input logic [63:0] f_data, input logic f_ide, input logic [17:0] f_ext);
        expect_frame(f_id, f_rtr, f_dlc, f_data, f_ide, f_ext);
        strobe_base = strobe_total;
        done_base   = done_total;
        id   = f_id;
        rtr  = f_rtr;
        dlc  = f_dlc;
        data = f_data;
`ifdef CAN_CRC_SEQ_EXT_EN
        ide    = f_ide;
        id_ext = f_ext;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clr_pulse", 32'(crc_clr), 32'd1);
        check("busy_start", 32'(busy), 32'd1);
        @(negedge clk);
        check("clr_single", 32'(crc_clr), 32'd0);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            bit_tick = 1'b1;
            @(negedge clk);
            bit_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 40 && done_total == done_base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_total - done_base), 32'd1);
        check({tag, "_strobes"}, 32'(strobe_total - strobe_base), 32'(exp_strobes));
        check({tag, "_crc_value"}, 32'(crc_value), 32'(exp_crc));
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_bit_out", 32'(bit_out), 32'd1);
        check("rst_strobe", 32'(bit_strobe), 32'd0);
        check("rst_crc_en", 32'(crc_en), 32'd0);
        check("rst_crc_clr", 32'(crc_clr), 32'd0);
        check("rst_phase", 32'(crc_phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_crc_value", 32'(crc_value), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Standard frame, no data.
        launch(11'h123, 1'b0, 4'd0, 64'd0, 1'b0, 18'd0);
        s1_crc = exp_crc;
        do_ticks(34);
        finish_frame("s1");

        // Two data bytes 0xA55A.
        launch(11'h7FF, 1'b0, 4'd2, {16'hA55A, 48'h0123_4567_89AB}, 1'b0, 18'd0);
        do_ticks(50);
        finish_frame("s2");

        // Remote frame: dlc sent as 1000, no data.
        launch(11'h2C3, 1'b1, 4'd8, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 18'd0);
        do_ticks(34);
        finish_frame("s3_rtr");

        // DLC 15 clamps to 8 bytes.
        launch(11'h055, 1'b0, 4'd15, 64'hF0E1_D2C3_B4A5_9687, 1'b0, 18'd0);
        do_ticks(98);
        finish_frame("s4_dlc15");
        s4_crc = exp_crc;

        // Abort after the 10th strobe.
        launch(11'h123, 1'b0, 4'd0, 64'd0, 1'b0, 18'd0);
        do_ticks(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_clr", 32'(crc_clr), 32'd1);
        check("abort_strobe", 32'(bit_strobe), 32'd0);
        check("abort_crc_en", 32'(crc_en), 32'd0);
        @(negedge clk);
        check("abort_clr_single", 32'(crc_clr), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_total - done_base), 32'd0);
        check("abort_strobes", 32'(strobe_total - strobe_base), 32'd10);
        check("abort_crc_kept", 32'(crc_value), 32'(s4_crc));
        sb_q.delete();

        // Same frame as s1 after the abort.
        launch(11'h123, 1'b0, 4'd0, 64'd0, 1'b0, 18'd0);
        do_ticks(34);
        finish_frame("s1_again");
        check("s1_repeat_crc", 32'(crc_value), 32'(s1_crc));

        // start during CRC phase must not restart or relatch.
        launch(11'h456, 1'b0, 4'd1, {8'h3C, 56'h0}, 1'b0, 18'd0);
        do_ticks(30);
        check("crc_phase_mid", 32'(crc_phase), 32'd1);
        check("busy_mid", 32'(busy), 32'd1);
        start = 1'b1;
        id    = 11'h0AA;
        @(negedge clk);
        start = 1'b0;
        do_ticks(12);
        finish_frame("start_ignored");

        // Reset mid-DATA.
        launch(11'h321, 1'b0, 4'd2, 64'hC3A5_0000_0000_0000, 1'b0, 18'd0);
        do_ticks(25);
        reset_n = 1'b0;
        #1;
        check("mid_rst_bit_out", 32'(bit_out), 32'd1);
        check("mid_rst_strobe", 32'(bit_strobe), 32'd0);
        check("mid_rst_crc_en", 32'(crc_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_phase", 32'(crc_phase), 32'd0);
        check("mid_rst_crc_value", 32'(crc_value), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        @(negedge clk);

`ifdef CAN_CRC_SEQ_EXT_EN
        // Extended header, no data: 39 + 15 strobes.
        launch(11'h123, 1'b0, 4'd0, 64'd0, 1'b1, 18'h2AAAA);
        do_ticks(54);
        finish_frame("ext");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
